dma_lite_wr_arbiter: RTL and testbench

- Shares the single AXI-Lite write master port of the DMA register interface between two configuration requesters:
  - requester 0: MM2S (read-side) sequencer.
  - requester 1: S2MM (write-side) sequencer.
- Arbitrates round-robin and runs one complete AW/W/B transaction per grant, returning BRESP and a done pulse to the winner.
- A watchdog aborts transactions the slave never answers.
- Sits between the per-channel register sequencers and the AXI DMA's `s_axi_lite` port.

---
 rtl/dma_lite_pkg.sv | 17 +
 rtl/rr_arb2.sv | 16 +
 rtl/dma_lite_wr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_dma_lite_wr_arbiter.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dma_lite_pkg.sv
// rtl/dma_lite_pkg.sv - shared types and constants for the DMA AXI-Lite arbiters
package dma_lite_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ADDR   = 2'd1,
        WAIT_B = 2'd2,
        DONE   = 2'd3
    } lite_arb_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic RQ_MM2S = 1'b0;
    localparam logic RQ_S2MM = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant selection, purely combinational
module rr_arb2
    import dma_lite_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant_idx,
    output logic       o_grant_valid
);

    assign o_grant_valid = |i_req;
    // Under contention the requester that did not win last time goes next.
    assign o_grant_idx   = (&i_req) ? ~i_last_grant
                         : (i_req[RQ_MM2S] ? RQ_MM2S : RQ_S2MM);

endmodule

// File: rtl/dma_lite_wr_arbiter.sv
// rtl/dma_lite_wr_arbiter.sv - shares one AXI-Lite write master between MM2S and S2MM sequencers
module dma_lite_wr_arbiter
    import dma_lite_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        rq_valid,
    input  logic [ADDR_W-1:0] rq_awaddr0,
    input  logic [ADDR_W-1:0] rq_awaddr1,
    input  logic [DATA_W-1:0] rq_wdata0,
    input  logic [DATA_W-1:0] rq_wdata1,
    output logic [1:0]        rq_end,
    output logic [1:0]        rq_resp,
    output logic              timeout,
    output logic [ADDR_W-1:0] m_axi_lite_awaddr,
    output logic              m_axi_lite_awvalid,
    input  logic              m_axi_lite_awready,
    output logic [DATA_W-1:0] m_axi_lite_wdata,
    output logic              m_axi_lite_wvalid,
    input  logic              m_axi_lite_wready,
    input  logic [1:0]        m_axi_lite_bresp,
    input  logic              m_axi_lite_bvalid,
    output logic              m_axi_lite_bready
);

    localparam logic [16:0] LP_TIMEOUT = 17'(TIMEOUT_CYC);

    lite_arb_state_t   r_state, w_state_n;
    logic              r_last_grant, w_last_grant_n;
    logic [15:0]       r_wd_cnt, w_wd_cnt_n, w_wd_inc;
    logic [ADDR_W-1:0] r_awaddr, w_awaddr_n;
    logic [DATA_W-1:0] r_wdata, w_wdata_n;
    logic              r_awvalid, w_awvalid_n;
    logic              r_wvalid, w_wvalid_n;
    logic              r_bready, w_bready_n;
    logic [1:0]        r_rq_end, w_rq_end_n;
    logic [1:0]        r_rq_resp, w_rq_resp_n;
    logic              r_timeout, w_timeout_n;
    logic              w_gnt_idx, w_gnt_valid, w_wd_fire, w_abort;
    logic              w_aw_pend, w_w_pend;

    rr_arb2 u_rr_arb2 (
        .i_req         (rq_valid),
        .i_last_grant  (r_last_grant),
        .o_grant_idx   (w_gnt_idx),
        .o_grant_valid (w_gnt_valid)
    );

    // Saturating watchdog; it fires on the cycle the incremented count reaches the limit.
    assign w_wd_inc  = (r_wd_cnt == 16'hFFFF) ? r_wd_cnt : r_wd_cnt + 16'd1;
    assign w_wd_fire = (TIMEOUT_CYC != 0) && ({1'b0, w_wd_inc} >= LP_TIMEOUT);
    assign w_aw_pend = r_awvalid & ~m_axi_lite_awready;
    assign w_w_pend  = r_wvalid  & ~m_axi_lite_wready;

    always_comb begin
        w_state_n      = r_state;
        w_last_grant_n = r_last_grant;
        w_wd_cnt_n     = r_wd_cnt;
        w_awaddr_n     = r_awaddr;
        w_wdata_n      = r_wdata;
        w_awvalid_n    = r_awvalid;
        w_wvalid_n     = r_wvalid;
        w_bready_n     = r_bready;
        w_rq_end_n     = 2'b00;
        w_rq_resp_n    = r_rq_resp;
        w_timeout_n    = 1'b0;
        w_abort        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_gnt_valid) begin
                    w_awaddr_n     = w_gnt_idx ? rq_awaddr1 : rq_awaddr0;
                    w_wdata_n      = w_gnt_idx ? rq_wdata1  : rq_wdata0;
                    w_awvalid_n    = 1'b1;
                    w_wvalid_n     = 1'b1;
                    w_last_grant_n = w_gnt_idx;
                    w_wd_cnt_n     = 16'd0;
                    w_state_n      = ADDR;
                end
            end
            ADDR: begin
                w_wd_cnt_n  = w_wd_inc;
                w_awvalid_n = w_aw_pend;
                w_wvalid_n  = w_w_pend;
                if (w_wd_fire) begin
                    w_abort = 1'b1;
                end else if (!w_aw_pend && !w_w_pend) begin
                    w_bready_n = 1'b1;
                    w_state_n  = WAIT_B;
                end
            end
            WAIT_B: begin
                w_wd_cnt_n = w_wd_inc;
                // A response arriving on the watchdog's final cycle still counts as real.
                if (r_bready && m_axi_lite_bvalid) begin
                    w_rq_resp_n              = m_axi_lite_bresp;
                    w_bready_n               = 1'b0;
                    w_rq_end_n[r_last_grant] = 1'b1;
                    w_state_n                = DONE;
                end else if (w_wd_fire) begin
                    w_abort = 1'b1;
                end
            end
            DONE: begin
                w_rq_resp_n = RESP_OKAY;
                w_state_n   = IDLE;
            end
            default: w_state_n = IDLE;
        endcase
        if (w_abort) begin
            w_awvalid_n              = 1'b0;
            w_wvalid_n               = 1'b0;
            w_bready_n               = 1'b0;
            w_rq_resp_n              = RESP_SLVERR;
            w_rq_end_n[r_last_grant] = 1'b1;
            w_timeout_n              = 1'b1;
            w_state_n                = DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= RQ_S2MM;
            r_wd_cnt     <= 16'd0;
            r_awaddr     <= '0;
            r_wdata      <= '0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
            r_rq_end     <= 2'b00;
            r_rq_resp    <= 2'b00;
            r_timeout    <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_last_grant <= w_last_grant_n;
            r_wd_cnt     <= w_wd_cnt_n;
            r_awaddr     <= w_awaddr_n;
            r_wdata      <= w_wdata_n;
            r_awvalid    <= w_awvalid_n;
            r_wvalid     <= w_wvalid_n;
            r_bready     <= w_bready_n;
            r_rq_end     <= w_rq_end_n;
            r_rq_resp    <= w_rq_resp_n;
            r_timeout    <= w_timeout_n;
        end
    end

    assign m_axi_lite_awaddr  = r_awaddr;
    assign m_axi_lite_awvalid = r_awvalid;
    assign m_axi_lite_wdata   = r_wdata;
    assign m_axi_lite_wvalid  = r_wvalid;
    assign m_axi_lite_bready  = r_bready;
    assign rq_end             = r_rq_end;
    assign rq_resp            = r_rq_resp;
    assign timeout            = r_timeout;

endmodule

// File: tb/tb_dma_lite_wr_arbiter.sv
// tb/tb_dma_lite_wr_arbiter.sv - self-checking bench for dma_lite_wr_arbiter
module tb_dma_lite_wr_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;
    localparam int TO     = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        rq_valid = 2'b00;
    logic [ADDR_W-1:0] rq_awaddr0 = '0, rq_awaddr1 = '0;
    logic [DATA_W-1:0] rq_wdata0 = '0, rq_wdata1 = '0;
    logic [1:0]        rq_end, rq_resp;
    logic              timeout;
    logic [ADDR_W-1:0] m_axi_lite_awaddr;
    logic              m_axi_lite_awvalid, m_axi_lite_wvalid, m_axi_lite_bready;
    logic [DATA_W-1:0] m_axi_lite_wdata;
    logic              m_axi_lite_awready = 1'b0, m_axi_lite_wready = 1'b0, m_axi_lite_bvalid = 1'b0;
    logic [1:0]        m_axi_lite_bresp = 2'b00;

    dma_lite_wr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .rq_valid(rq_valid),
        .rq_awaddr0(rq_awaddr0), .rq_awaddr1(rq_awaddr1),
        .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1),
        .rq_end(rq_end), .rq_resp(rq_resp), .timeout(timeout),
        .m_axi_lite_awaddr(m_axi_lite_awaddr), .m_axi_lite_awvalid(m_axi_lite_awvalid),
        .m_axi_lite_awready(m_axi_lite_awready), .m_axi_lite_wdata(m_axi_lite_wdata),
        .m_axi_lite_wvalid(m_axi_lite_wvalid), .m_axi_lite_wready(m_axi_lite_wready),
        .m_axi_lite_bresp(m_axi_lite_bresp), .m_axi_lite_bvalid(m_axi_lite_bvalid),
        .m_axi_lite_bready(m_axi_lite_bready)
    );

    always #5 clk = ~clk;

    int total = 0, passed = 0, fails = 0;
    int cyc = 0;

    // Reference model: one outstanding write, described by grant cycle and slave delays.
    bit        busy, prev_win, win, exp_to;
    bit [1:0]  drop;
    int        free_cyc, g_cyc, lat;
    int        aw_d, w_d, b_d;
    logic [1:0]        bresp_sel, exp_resp;
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;

    // Directed controls
    bit        rand_mode;
    logic [1:0] f_valid;
    int        f_aw_d, f_w_d, f_b_d;
    logic [1:0] f_bresp;
    logic [ADDR_W-1:0] f_addr0, f_addr1;
    logic [DATA_W-1:0] f_data0, f_data1;

    int aw_cnt, w_cnt, b_cnt;
    int obs_cnt = 0;
    bit obs_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        busy = 0; free_cyc = 0; prev_win = 1; drop = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        m_axi_lite_awready = 0; m_axi_lite_wready = 0; m_axi_lite_bvalid = 0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_awaddr"}, 32'(m_axi_lite_awaddr), 0);
        chk({tag, "_wdata"}, m_axi_lite_wdata, 0);
        chk({tag, "_valids"}, {29'd0, m_axi_lite_awvalid, m_axi_lite_wvalid, m_axi_lite_bready}, 0);
        chk({tag, "_rq_end"}, 32'(rq_end), 0);
        chk({tag, "_rq_resp"}, 32'(rq_resp), 0);
        chk({tag, "_timeout"}, 32'(timeout), 0);
    endtask

    task automatic step();
        int k, m;
        bit at_done;
        bit [1:0] cur_drop;
        logic [1:0] rqv;
        @(posedge clk); #1; cyc++;
        cur_drop = drop; drop = 2'b00;
        k = cyc - g_cyc;
        m = (aw_d > w_d) ? aw_d : w_d;
        at_done = busy && (k == lat);
        chk("awvalid", 32'(m_axi_lite_awvalid), 32'(busy && k >= 1 && k <= 1 + aw_d && k < lat));
        chk("wvalid", 32'(m_axi_lite_wvalid), 32'(busy && k >= 1 && k <= 1 + w_d && k < lat));
        chk("bready", 32'(m_axi_lite_bready), 32'(busy && k >= 2 + m && k < lat));
        if (busy && k >= 1) begin
            chk("awaddr", 32'(m_axi_lite_awaddr), 32'(exp_addr));
            chk("wdata", m_axi_lite_wdata, exp_data);
        end
        chk("rq_end", 32'(rq_end), at_done ? (32'd1 << win) : 32'd0);
        chk("timeout", 32'(timeout), 32'(at_done && exp_to));
        if (at_done) begin
            chk("rq_resp", 32'(rq_resp), 32'(exp_resp));
            busy = 0; free_cyc = cyc + 1; drop = 2'b01 << win;
        end
        if (rq_end != 2'b00) begin
            obs_cnt++;
            obs_log.push_back(rq_end[1]);
        end
        // Slave: each channel answers after its programmed number of stall cycles.
        if (m_axi_lite_awvalid) begin m_axi_lite_awready = (aw_cnt >= aw_d); aw_cnt++; end
        else begin m_axi_lite_awready = 0; aw_cnt = 0; end
        if (m_axi_lite_wvalid) begin m_axi_lite_wready = (w_cnt >= w_d); w_cnt++; end
        else begin m_axi_lite_wready = 0; w_cnt = 0; end
        if (m_axi_lite_bready) begin m_axi_lite_bvalid = (b_cnt >= b_d); b_cnt++; end
        else begin m_axi_lite_bvalid = 0; b_cnt = 0; end
        m_axi_lite_bresp = bresp_sel;
        // Requesters
        if (rand_mode) begin
            rqv = {1'($urandom_range(3) != 0), 1'($urandom_range(3) != 0)};
            rq_awaddr0 = ADDR_W'($urandom); rq_awaddr1 = ADDR_W'($urandom);
            rq_wdata0 = $urandom; rq_wdata1 = $urandom;
        end else begin
            rqv = f_valid;
            rq_awaddr0 = f_addr0; rq_awaddr1 = f_addr1;
            rq_wdata0 = f_data0; rq_wdata1 = f_data1;
        end
        rqv = rqv & ~cur_drop;
        rq_valid = rqv;
        if (!busy && cyc >= free_cyc && rqv != 2'b00) begin
            win = (rqv == 2'b11) ? ~prev_win : rqv[1];
            prev_win = win; g_cyc = cyc; busy = 1;
            exp_addr = win ? rq_awaddr1 : rq_awaddr0;
            exp_data = win ? rq_wdata1 : rq_wdata0;
            if (rand_mode) begin
                aw_d = $urandom_range(5); w_d = $urandom_range(5); b_d = $urandom_range(5);
                bresp_sel = 2'($urandom_range(3));
                m = (aw_d > w_d) ? aw_d : w_d;
                if (m + b_d == TO - 2) b_d++;
            end else begin
                aw_d = f_aw_d; w_d = f_w_d; b_d = f_b_d; bresp_sel = f_bresp;
            end
            m = (aw_d > w_d) ? aw_d : w_d;
            // Best case is 3 cycles grant-to-done; the watchdog ends it TO+1 cycles after grant.
            if (m + b_d > TO - 2) begin lat = TO + 1; exp_to = 1; exp_resp = 2'b10; end
            else begin lat = 3 + m + b_d; exp_to = 0; exp_resp = bresp_sel; end
        end
    endtask

    task automatic run_until(input int target, input int budget);
        int n = 0;
        while (obs_cnt < target && n < budget) begin step(); n++; end
        chk("wait_budget", obs_cnt, target);
    endtask

    task automatic set_dir(input logic [1:0] v, input int ad, input int wd, input int bd, input logic [1:0] br);
        f_valid = v; f_aw_d = ad; f_w_d = wd; f_b_d = bd; f_bresp = br;
    endtask

    initial begin
        rand_mode = 0;
        f_addr0 = 10'h030; f_data0 = 32'h0000_0001;
        f_addr1 = 10'h048; f_data1 = 32'hCAFE_0048;
        aw_d = 0; w_d = 0; b_d = 0; bresp_sel = 2'b00; g_cyc = 0; lat = 0;
        set_dir(2'b00, 0, 0, 0, 2'b00);
        model_reset();
        #13;
        chk_all_zero("reset");
        @(posedge clk); #2 rst = 0;

        // Contention straight out of reset: 0 first, then strict alternation.
        obs_log.delete();
        set_dir(2'b11, 0, 0, 0, 2'b00);
        run_until(obs_cnt + 4, 40);
        chk("alt_count", obs_log.size(), 4);
        for (int i = 0; i < 4 && i < obs_log.size(); i++)
            chk("alt_order", 32'(obs_log[i]), 32'(i % 2));
        f_valid = 2'b00; step(); step(); step(); step();

        // Single MM2S write, all ready.
        set_dir(2'b01, 0, 0, 0, 2'b00);
        run_until(obs_cnt + 1, 20);
        f_valid = 2'b00; step(); step();

        // AW accepted immediately, W stalled four cycles.
        set_dir(2'b01, 0, 4, 0, 2'b00);
        run_until(obs_cnt + 1, 20);
        f_valid = 2'b00; step(); step();

        // Watchdog with awready stuck low, then S2MM error response right behind it.
        set_dir(2'b01, 40, 0, 0, 2'b00);
        run_until(obs_cnt + 1, 20);
        set_dir(2'b10, 0, 0, 0, 2'b10);
        run_until(obs_cnt + 1, 20);
        f_valid = 2'b00; step(); step();

        // Randomised traffic, payload churn and slave stalls.
        rand_mode = 1;
        run_until(obs_cnt + 150, 3000);
        rand_mode = 0; f_valid = 2'b00;
        for (int i = 0; i < 12; i++) step();

        // Reset while waiting for B.
        set_dir(2'b01, 0, 0, 5, 2'b00);
        f_data0 = 32'h5A5A_5A5A;
        step(); step(); step();
        #2 rst = 1;
        #1 chk_all_zero("async_rst");
        f_valid = 2'b00; rq_valid = 2'b00;
        model_reset();
        @(posedge clk); #2 rst = 0;
        obs_log.delete();
        set_dir(2'b11, 0, 0, 0, 2'b00);
        run_until(obs_cnt + 1, 20);
        chk("post_rst_count", obs_log.size(), 1);
        if (obs_log.size() > 0) chk("post_rst_winner", 32'(obs_log[0]), 0);
        f_valid = 2'b00;
        for (int i = 0; i < 6; i++) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
